// File: rtl/writeback.sv
// -----------------------------------------------------------------------------
// writeback
//   Final pipeline stage. Commits execute-stage results into the architectural
//   register file it owns, exposes two combinational read ports with a
//   same-cycle write-to-read bypass, and reports a registered forwarding
//   bundle, a retired-instruction counter and a sticky halt flag.
//
// Ports
//   clock         in   system clock, all state updates on the rising edge
//   reset         in   synchronous, active-high; wins over any commit
//   EX_WB         in   [4:0] dest, [36:5] result, [37] valid, [38] halt,
//                      upper bits reserved and ignored
//   rd_addr_a/b   in   decode read indices
//   rd_data_a/b   out  read data (combinational, r0 reads as zero)
//   fwd_valid     out  a result was committed on the previous edge
//   fwd_dest      out  destination of the most recent commit
//   fwd_data      out  data of the most recent commit
//   retired_count out  committed-instruction count, wraps modulo 2^32
//   halted        out  sticky; set by a committed halt, cleared by reset
// -----------------------------------------------------------------------------
module writeback #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int EXWB_WIDTH = 128
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [EXWB_WIDTH-1:0] EX_WB,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  fwd_valid,
  output logic [ADDR_WIDTH-1:0] fwd_dest,
  output logic [DATA_WIDTH-1:0] fwd_data,
  output logic [31:0]           retired_count,
  output logic                  halted
);

  localparam int ValidBit = ADDR_WIDTH + DATA_WIDTH;
  localparam int HaltBit  = ValidBit + 1;

  // Bundle fields.
  logic [ADDR_WIDTH-1:0] ex_dest;
  logic [DATA_WIDTH-1:0] ex_result;
  logic                  ex_valid;
  logic                  ex_halt;
  logic                  unused_reserved;

  assign ex_dest         = EX_WB[ADDR_WIDTH-1:0];
  assign ex_result       = EX_WB[ADDR_WIDTH +: DATA_WIDTH];
  assign ex_valid        = EX_WB[ValidBit];
  assign ex_halt         = EX_WB[HaltBit];
  assign unused_reserved = ^EX_WB[EXWB_WIDTH-1:HaltBit+1];

  // State.
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic                  fwd_valid_q, fwd_valid_d;
  logic [ADDR_WIDTH-1:0] fwd_dest_q,  fwd_dest_d;
  logic [DATA_WIDTH-1:0] fwd_data_q,  fwd_data_d;
  logic [31:0]           count_q,     count_d;
  logic                  halted_q,    halted_d;

  // Once halted, every beat is ignored, including its bypass.
  logic commit;
  assign commit = ex_valid && !halted_q;

  // Next-state logic for the control/status registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    fwd_valid_d = 1'b0;
    fwd_dest_d  = fwd_dest_q;
    fwd_data_d  = fwd_data_q;
    count_d     = count_q;
    halted_d    = halted_q;
    if (commit) begin
      fwd_valid_d = 1'b1;
      fwd_dest_d  = ex_dest;     // reported even for r0
      fwd_data_d  = ex_result;
      count_d     = count_q + 32'd1;
      halted_d    = ex_halt;     // halted_q is 0 whenever commit is true
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      // NOTE: the register file is cleared on reset because software relies
      // on architecturally zeroed registers; this keeps it out of RAM macros.
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      fwd_valid_q <= 1'b0;
      fwd_dest_q  <= '0;
      fwd_data_q  <= '0;
      count_q     <= '0;
      halted_q    <= 1'b0;
    end else begin
      if (commit && ex_dest != '0) regs_q[ex_dest] <= ex_result;
      fwd_valid_q <= fwd_valid_d;
      fwd_dest_q  <= fwd_dest_d;
      fwd_data_q  <= fwd_data_d;
      count_q     <= count_d;
      halted_q    <= halted_d;
    end
  end

  // Read ports: r0 is hard zero, then same-cycle bypass, then the array.
  assign rd_data_a = (rd_addr_a == '0)                ? '0 :
                     (commit && rd_addr_a == ex_dest) ? ex_result :
                                                        regs_q[rd_addr_a];
  assign rd_data_b = (rd_addr_b == '0)                ? '0 :
                     (commit && rd_addr_b == ex_dest) ? ex_result :
                                                        regs_q[rd_addr_b];

  assign fwd_valid     = fwd_valid_q;
  assign fwd_dest      = fwd_dest_q;
  assign fwd_data      = fwd_data_q;
  assign retired_count = count_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_writeback.sv
// -----------------------------------------------------------------------------
// tb_writeback
//   Self-checking bench for writeback. A behavioural model of the register
//   file, forwarding bundle, counter and halt flag is updated on every rising
//   edge; a compare process checks every DUT output against it on each
//   falling edge. Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_writeback;

  logic         clock;
  logic         reset;
  logic [127:0] EX_WB;
  logic [4:0]   rd_addr_a, rd_addr_b;
  logic [31:0]  rd_data_a, rd_data_b;
  logic         fwd_valid;
  logic [4:0]   fwd_dest;
  logic [31:0]  fwd_data;
  logic [31:0]  retired_count;
  logic         halted;

  writeback dut (
    .clock         (clock),
    .reset         (reset),
    .EX_WB         (EX_WB),
    .rd_addr_a     (rd_addr_a),
    .rd_addr_b     (rd_addr_b),
    .rd_data_a     (rd_data_a),
    .rd_data_b     (rd_data_b),
    .fwd_valid     (fwd_valid),
    .fwd_dest      (fwd_dest),
    .fwd_data      (fwd_data),
    .retired_count (retired_count),
    .halted        (halted)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Current beat as presented, kept as separate fields for the model.
  logic        cur_valid, cur_halt;
  logic [4:0]  cur_dest;
  logic [31:0] cur_result;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  name, got, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_regs [32];
  logic        m_fwd_valid, m_halted;
  logic [4:0]  m_fwd_dest;
  logic [31:0] m_fwd_data, m_count;
  bit          chk_en = 1'b0;

  function automatic logic [31:0] m_read(input logic [4:0] addr);
    if (addr == 5'd0) return 32'h0;
    if (cur_valid && !m_halted && addr == cur_dest) return cur_result;
    return m_regs[addr];
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
      m_fwd_valid = 1'b0;
      m_fwd_dest  = 5'd0;
      m_fwd_data  = 32'h0;
      m_count     = 32'h0;
      m_halted    = 1'b0;
    end else if (cur_valid && !m_halted) begin
      if (cur_dest != 5'd0) m_regs[cur_dest] = cur_result;
      m_fwd_valid = 1'b1;
      m_fwd_dest  = cur_dest;
      m_fwd_data  = cur_result;
      m_count     = m_count + 32'd1;
      if (cur_halt) m_halted = 1'b1;
    end else begin
      m_fwd_valid = 1'b0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (chk_en) begin
      check("cmp_rd_a",  rd_data_a,            m_read(rd_addr_a));
      check("cmp_rd_b",  rd_data_b,            m_read(rd_addr_b));
      check("cmp_fwd_v", {31'h0, fwd_valid},   {31'h0, m_fwd_valid});
      check("cmp_fwd_d", {27'h0, fwd_dest},    {27'h0, m_fwd_dest});
      check("cmp_fwd_x", fwd_data,             m_fwd_data);
      check("cmp_count", retired_count,        m_count);
      check("cmp_halt",  {31'h0, halted},      {31'h0, m_halted});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drives a beat; reserved bits carry random junk that must be ignored.
  task automatic drive(input logic v, input logic h, input logic [4:0] d,
                       input logic [31:0] r);
    logic [95:0] junk;
    junk       = {$urandom, $urandom, $urandom};
    cur_valid  = v;
    cur_halt   = h;
    cur_dest   = d;
    cur_result = r;
    EX_WB      = {junk[88:0], h, v, r, d};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    reset = 1'b1;
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd0;
    idle();
    tick();
    tick();
    reset = 1'b0;
    chk_en = 1'b1;

    // 1. Reset state: every register reads zero.
    check("rst_fwd_valid", {31'h0, fwd_valid}, 32'h0);
    check("rst_count",     retired_count,      32'h0);
    check("rst_halted",    {31'h0, halted},    32'h0);
    for (int i = 0; i < 32; i++) begin
      rd_addr_a = 5'(i);
      rd_addr_b = 5'(31 - i);
      #1;
      check("rst_rd_a", rd_data_a, 32'h0);
      check("rst_rd_b", rd_data_b, 32'h0);
      tick();
    end

    // 2. Write then read.
    drive(1'b1, 1'b0, 5'd7, 32'hDEADBEEF);
    tick();
    idle();
    rd_addr_a = 5'd7;
    #1;
    check("wr_rd_a",     rd_data_a,             32'hDEADBEEF);
    check("wr_fwd_v",    {31'h0, fwd_valid},    32'h1);
    check("wr_fwd_dest", {27'h0, fwd_dest},     32'h7);
    check("wr_fwd_data", fwd_data,              32'hDEADBEEF);
    check("wr_count",    retired_count,         32'h1);
    tick();
    check("idle_fwd_v",    {31'h0, fwd_valid}, 32'h0);
    check("idle_fwd_hold", fwd_data,           32'hDEADBEEF);

    // Halt bit without valid has no effect.
    drive(1'b0, 1'b1, 5'd6, 32'h66);
    tick();
    idle();
    #1;
    check("halt_novalid", {31'h0, halted}, 32'h0);

    // 3. r0 write is dropped but still retires and forwards.
    drive(1'b1, 1'b0, 5'd3, 32'h11);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h12345678);
    tick();
    idle();
    rd_addr_a = 5'd0;
    rd_addr_b = 5'd3;
    #1;
    check("r0_rd",       rd_data_a,          32'h0);
    check("r0_count",    retired_count,      32'h3);
    check("r0_fwd_v",    {31'h0, fwd_valid}, 32'h1);
    check("r0_fwd_data", fwd_data,           32'h12345678);
    check("r3_before",   rd_data_b,          32'h11);
    tick();
    // Same-cycle bypass on both ports.
    drive(1'b1, 1'b0, 5'd3, 32'hA5A5A5A5);
    rd_addr_a = 5'd3;
    rd_addr_b = 5'd3;
    #1;
    check("bypass_b", rd_data_b, 32'hA5A5A5A5);
    check("bypass_a", rd_data_a, 32'hA5A5A5A5);
    tick();
    idle();

    // 4. Halt: fresh reset so the count starts from zero.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b1, 5'd4, 32'h44);
    tick();
    drive(1'b1, 1'b0, 5'd5, 32'h55);
    rd_addr_a = 5'd5;
    #1;
    check("halt_no_bypass", rd_data_a, 32'h0);
    tick();
    idle();
    rd_addr_a = 5'd4;
    rd_addr_b = 5'd5;
    #1;
    check("halt_r4",    rd_data_a,          32'h44);
    check("halt_r5",    rd_data_b,          32'h0);
    check("halt_flag",  {31'h0, halted},    32'h1);
    check("halt_count", retired_count,      32'h1);
    check("halt_fwd_v", {31'h0, fwd_valid}, 32'h0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("halt_cleared", {31'h0, halted}, 32'h0);

    // 5. Counter wrap from a deposited value.
    dut.count_q = 32'hFFFF_FFFE;
    m_count     = 32'hFFFF_FFFE;
    drive(1'b1, 1'b0, 5'd10, 32'hA);
    tick();
    check("wrap_1", retired_count, 32'hFFFF_FFFF);
    drive(1'b1, 1'b0, 5'd11, 32'hB);
    tick();
    check("wrap_2", retired_count, 32'h0000_0000);
    drive(1'b1, 1'b0, 5'd12, 32'hC);
    tick();
    check("wrap_3", retired_count, 32'h0000_0001);

    // 6. Reset on the same edge as a valid beat discards it.
    drive(1'b1, 1'b0, 5'd9, 32'h99);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    idle();
    rd_addr_a = 5'd9;
    #1;
    check("midrst_r9",    rd_data_a,          32'h0);
    check("midrst_fwd_v", {31'h0, fwd_valid}, 32'h0);
    check("midrst_count", retired_count,      32'h0);
    tick();
    tick();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/writeback.md
Name: writeback

Overview:
- Final pipeline stage. Consumes the EX_WB bundle from the execute stage and commits results to the architectural register file (32 x 32-bit), which it owns.
- Provides two combinational read ports for the decode stage, with write-to-read bypass.
- Provides a registered forwarding bundle back to execute, a retired-instruction counter, and a sticky halt flag.

Parameters:
- DATA_WIDTH, 32, register and result width
- NUM_REGS, 32, number of architectural registers
- ADDR_WIDTH, 5, register index width
- EXWB_WIDTH, 128, width of the EX_WB bundle

Ports:
- clock  input  1  single system clock, all state updates on posedge
- reset  input  1  synchronous, active-high
- EX_WB  input  128  execute-to-writeback bundle: [4:0] dest, [36:5] result, [37] valid (write request), [38] halt, [127:39] reserved/ignored
- rd_addr_a  input  5  decode read port A index
- rd_addr_b  input  5  decode read port B index
- rd_data_a  output  32  read data A (combinational)
- rd_data_b  output  32  read data B (combinational)
- fwd_valid  output  1  registered: a result was committed last cycle
- fwd_dest  output  5  registered destination of last commit
- fwd_data  output  32  registered data of last commit
- retired_count  output  32  number of committed instructions
- halted  output  1  sticky halt indication

Behaviour:
- Reset (synchronous, sampled at posedge clock, active-high):
  - All 32 registers, fwd_valid, fwd_dest, fwd_data, retired_count and halted become 0.
  - Reset has priority over every other event.
  - Reset asserted mid-stream discards the EX_WB beat present on that edge.
- Commit condition: commit = EX_WB[37] && !halted.
- On posedge with commit:
  - If dest != 0, regs[dest] <= result. Writes to r0 are dropped.
  - fwd_valid <= 1, fwd_dest <= dest, fwd_data <= result. This applies even for dest == 0.
  - retired_count <= retired_count + 1, modulo 2^32 (0xFFFFFFFF wraps to 0).
- On posedge without commit:
  - fwd_valid <= 0.
  - fwd_dest and fwd_data hold their values.
  - No register or counter change.
- Halt:
  - If commit && EX_WB[38], halted <= 1 on the same edge.
  - The halting instruction itself commits and retires.
  - Once halted = 1, all later beats are ignored, fwd_valid stays 0 and the counter freezes.
  - Only reset clears halted.
  - EX_WB[38] with EX_WB[37] = 0 has no effect.
- Latency:
  - Result is in the register file one edge after presentation.
  - fwd_* are valid in the cycle following the commit edge.
- Read ports (combinational, identical rules for A and B):
  - addr == 0 returns 0.
  - Otherwise, if commit && addr == dest, return the EX_WB result (same-cycle bypass).
  - Otherwise return regs[addr].
  - A and B may address the same register simultaneously; both return the same value.
- Reserved bits [127:39] have no effect.
- No backpressure: one beat accepted per cycle, no stall output.

Test Plan:
1. Reset check: reset high 2 cycles, then low -> rd_data_a/b = 0 for all 32 addresses; fwd_valid = 0; retired_count = 0; halted = 0.
2. Write then read: EX_WB valid = 1, dest = 7, result = 0xDEADBEEF for 1 cycle, then rd_addr_a = 7 -> rd_data_a = 0xDEADBEEF; next cycle fwd_valid = 1, fwd_dest = 7, fwd_data = 0xDEADBEEF; retired_count = 1; the following idle cycle gives fwd_valid = 0.
3. r0 and bypass: valid write dest = 0, result = 0x12345678 -> rd_data(0) = 0, retired_count increments, fwd_valid = 1. Then, during a cycle with valid write dest = 3, result = 0xA5A5A5A5 (r3 previously 0x11), rd_addr_b = 3 -> rd_data_b = 0xA5A5A5A5 in that same cycle.
4. Halt: valid beat dest = 4, result = 0x44, halt = 1, then valid beat dest = 5, result = 0x55 -> r4 = 0x44, r5 unchanged (0), halted = 1, retired_count = 1, fwd_valid = 0 after the halt cycle. Assert reset -> halted = 0.
5. Counter wrap: preload retired_count = 0xFFFFFFFE (hierarchical deposit), issue 3 valid beats -> count reads 0xFFFFFFFF, 0x00000000, 0x00000001.
6. Reset mid-operation: reset high on the same edge as valid write dest = 9, result = 0x99 -> r9 = 0, fwd_valid = 0, retired_count = 0.
